pipe_stage_reg: RTL and testbench

//  Generic, parametrised pipeline-stage register replacing the fixed per-stage registers
//  (IF/ID, ID/EX, EX/MEM, MEM/WB). Adds valid/ready flow control, synchronous flush with

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage_reg_if.sv | 16 +
 rtl/pipe_slot.sv | 53 +++++
 rtl/pipe_stage_reg.sv | 66 ++++++
 tb/tb_pipe_stage_reg.sv | 132 +++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, control struct and constants for pipeline stage registers
//   WORD_LEN / INSTRUCTION_LEN : datapath and instruction widths
//   ex_mem_ctrl_t              : control field carried with each entry (10 bits)
//   NOP_INSTR                  : instruction presented in empty slots
//   occ_t                      : stage occupancy count (0..2)
package pipe_pkg;
    localparam int WORD_LEN = 32;
    localparam int INSTRUCTION_LEN = 32;
    typedef struct packed {
        logic       mem_write;
        logic       mem_read;
        logic [1:0] wb_sel;
        logic       rf_we;
        logic       cin;
        logic [3:0] alu_op;
    } ex_mem_ctrl_t;
    localparam int CTRL_LEN = $bits(ex_mem_ctrl_t);
    localparam logic [INSTRUCTION_LEN-1:0] NOP_INSTR = '0;
    typedef logic [1:0] occ_t;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake bundle carrying ctrl, data and instruction
//   master: drives valid/ctrl/data/instr, receives ready
//   slave : receives valid/ctrl/data/instr, drives ready
interface pipe_stage_reg_if #(
    parameter int CTRL_W  = pipe_pkg::CTRL_LEN,
    parameter int DATA_W  = 2 * pipe_pkg::WORD_LEN,
    parameter int INSTR_W = pipe_pkg::INSTRUCTION_LEN
);
    logic               valid;
    logic               ready;
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  data;
    logic [INSTR_W-1:0] instr;
    modport master (output valid, ctrl, data, instr, input ready);
    modport slave  (input valid, ctrl, data, instr, output ready);
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one stage entry (valid + ctrl + data + instr) with load control
//   clk, rst    : clock, async active-low reset
//   load, vld   : on load the valid flop takes vld; payload is only captured when vld=1,
//                 so clearing a slot keeps the old data
//   *_i / *_o   : entry in / stored entry out
module pipe_slot #(
    parameter int CTRL_W  = 10,
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               vld,
    input  logic [CTRL_W-1:0]  ctrl_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [INSTR_W-1:0] instr_o
);
    logic               valid_d, valid_q;
    logic [CTRL_W-1:0]  ctrl_d, ctrl_q;
    logic [DATA_W-1:0]  data_d, data_q;
    logic [INSTR_W-1:0] instr_d, instr_q;

    always_comb begin
        valid_d = load ? vld : valid_q;
        ctrl_d  = load && vld ? ctrl_i  : ctrl_q;
        data_d  = load && vld ? data_i  : data_q;
        instr_d = load && vld ? instr_i : instr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
    assign instr_o = instr_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline-stage register with valid/ready flow control, flush and optional skid entry
//   clk, rst  : clock, async active-low reset
//   flush     : synchronous kill of all stored entries (blocks acceptance that cycle)
//   up        : upstream handshake (slave)
//   dn        : downstream handshake (master); ctrl/instr read as zero when not valid
//   occupancy : number of entries held
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int DATA_W  = 2 * WORD_LEN,
    parameter int CTRL_W  = $bits(ex_mem_ctrl_t),
    parameter int INSTR_W = INSTRUCTION_LEN,
    parameter bit SKID    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    pipe_stage_reg_if.slave         up,
    pipe_stage_reg_if.master        dn,
    output occ_t                    occupancy
);
    logic               h_valid, s_valid;
    logic [CTRL_W-1:0]  h_ctrl, s_ctrl, h_ctrl_i;
    logic [DATA_W-1:0]  h_data, s_data, h_data_i;
    logic [INSTR_W-1:0] h_instr, s_instr, h_instr_i;
    logic               accept, head_free, h_load, h_vld;

    // With a skid entry, ready depends only on the skid flop, so no out_ready -> in_ready path.
    // The skid entry is always older than anything upstream, so it refills the head first.
    always_comb begin
        head_free = !h_valid || dn.ready;
        up.ready  = rst && !flush && (SKID ? !s_valid : head_free);
        accept    = up.valid && up.ready;
        h_load    = flush || head_free;
        h_vld     = !flush && (s_valid || accept);
        h_ctrl_i  = s_valid ? s_ctrl  : up.ctrl;
        h_data_i  = s_valid ? s_data  : up.data;
        h_instr_i = s_valid ? s_instr : up.instr;
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) u_head (
        .clk(clk), .rst(rst), .load(h_load), .vld(h_vld),
        .ctrl_i(h_ctrl_i), .data_i(h_data_i), .instr_i(h_instr_i),
        .valid_o(h_valid), .ctrl_o(h_ctrl), .data_o(h_data), .instr_o(h_instr)
    );

    if (SKID) begin : g_skid
        // Skid reloads when it empties into the head, or catches an entry the busy head cannot take.
        pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) u_skid (
            .clk(clk), .rst(rst),
            .load(flush || (s_valid ? head_free : !head_free && accept)),
            .vld(!flush && accept),
            .ctrl_i(up.ctrl), .data_i(up.data), .instr_i(up.instr),
            .valid_o(s_valid), .ctrl_o(s_ctrl), .data_o(s_data), .instr_o(s_instr)
        );
    end else begin : g_no_skid
        assign s_valid = 1'b0;
        assign s_ctrl  = '0;
        assign s_data  = '0;
        assign s_instr = '0;
    end

    assign dn.valid  = h_valid;
    assign dn.ctrl   = h_valid ? h_ctrl : '0;
    assign dn.data   = h_data;
    assign dn.instr  = h_valid ? h_instr : INSTR_W'(NOP_INSTR);
    assign occupancy = {h_valid & s_valid, h_valid ^ s_valid};
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench running SKID=1 (dut0) and SKID=0 (dut1) side by side
module tb_pipe_stage_reg;
    localparam int CW = pipe_pkg::CTRL_LEN;
    localparam int DW = 64;
    localparam int IW = 32;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic iv [2];
    logic ordy [2];
    logic [CW-1:0] ictrl [2];
    logic [DW-1:0] idata [2];
    logic [IW-1:0] iinstr [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW), .INSTR_W(IW)) up ();
        pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW), .INSTR_W(IW)) dn ();
        pipe_pkg::occ_t occ;
        ent_t q[$];

        assign up.valid = iv[g];
        assign up.ctrl  = ictrl[g];
        assign up.data  = idata[g];
        assign up.instr = iinstr[g];
        assign dn.ready = ordy[g];

        pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .INSTR_W(IW), .SKID(g == 0)) u_dut (
            .clk(clk), .rst(rst), .flush(flush), .up(up), .dn(dn), .occupancy(occ)
        );

        // Reference: a FIFO of capacity 2 (SKID=1) or a 1-entry pass-through (SKID=0).
        always @(posedge clk or negedge rst) begin
            int n;
            bit r;
            if (!rst) q.delete();
            else begin
                n = q.size();
                r = !flush && (g == 0 ? n < 2 : (n == 0 || ordy[g]));
                if (n > 0 && ordy[g]) void'(q.pop_front());
                if (flush) q.delete();
                else if (iv[g] && r) q.push_back('{ictrl[g], idata[g], iinstr[g]});
            end
        end

        // Monitor: compares what the DUT presents against the head of the expected queue.
        always @(negedge clk) begin
            int n;
            #2;
            n = q.size();
            chk("in_ready", g, 64'(up.ready), 64'(rst && !flush && (g == 0 ? n < 2 : (n == 0 || ordy[g]))));
            chk("out_valid", g, 64'(dn.valid), 64'(n > 0));
            chk("occupancy", g, 64'(occ), 64'(n));
            chk("out_ctrl", g, 64'(dn.ctrl), n > 0 ? 64'(q[0].c) : 64'(0));
            chk("out_instr", g, 64'(dn.instr), n > 0 ? 64'(q[0].i) : 64'(0));
            if (n > 0) chk("out_data", g, dn.data, q[0].d);
        end
    end

    task automatic drive(input bit v, input bit r, input bit f, input logic [63:0] d);
        for (int k = 0; k < 2; k++) begin
            iv[k]     = v;
            ordy[k]   = r;
            ictrl[k]  = CW'($urandom);
            idata[k]  = d;
            iinstr[k] = $urandom;
        end
        flush = f;
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; ordy[k] = 1'b0; ictrl[k] = '1; idata[k] = '1; iinstr[k] = '1;
        end
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 0, 64'(g_dut[0].up.ready), 64'(0));
        chk("reset_occupancy", 0, 64'(g_dut[0].occ), 64'(0));
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) drive(1, 1, 0, 64'(i));
        repeat (2) drive(0, 1, 0, 0);
        for (int i = 11; i <= 13; i++) drive(1, 0, 0, 64'(i));
        chk("bp_occupancy", 0, 64'(g_dut[0].occ), 64'(2));
        chk("bp_in_ready", 0, 64'(g_dut[0].up.ready), 64'(0));
        repeat (3) drive(0, 1, 0, 0);
        drive(1, 0, 0, 21);
        drive(1, 0, 0, 22);
        drive(1, 1, 1, 23);
        chk("flush_out_valid", 0, 64'(g_dut[0].dn.valid), 64'(0));
        chk("flush_occupancy", 0, 64'(g_dut[0].occ), 64'(0));
        drive(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, i[0], 0, 64'(30 + i));
        repeat (400) drive($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(19) == 0,
                           {$urandom, $urandom});
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; ordy[k] = 1'b0;
        end
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_out_valid", k, 64'(k == 0 ? g_dut[0].dn.valid : g_dut[1].dn.valid), 64'(0));
            chk("async_occupancy", k, 64'(k == 0 ? g_dut[0].occ : g_dut[1].occ), 64'(0));
        end
        @(negedge clk);
        repeat (2) drive(1, 1, 0, 64'hdead);
        rst = 1'b1;
        repeat (50) drive($urandom_range(1) != 0, $urandom_range(1) != 0, 0, {$urandom, $urandom});
        repeat (3) drive(0, 1, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
